// File: rtl/prefetch_ifu.sv
// prefetch_ifu: instruction prefetch queue in front of a combinational
// instruction memory. Fetches sequentially from fetch_pc into a DEPTH-entry
// FIFO of {pc, instr, adel}. Redirects, exception entries and exception
// returns flush the queue and retarget the fetch. Fetch stops after an
// address-error entry and stays stopped until the next flush.
//
// Optional feature: define PREFETCH_IFU_FLUSH_CNT_EN to build a saturating
// count of flush cycles on flush_count. Without it, flush_count is tied to 0.
module prefetch_ifu #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] PC_START   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] ADDR_LO    = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    // instruction memory
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    // head-entry handshake
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr,
    output logic        deq_adel,
    // control-flow changes
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    // statistics
    output logic [31:0] flush_count
);

    // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits;
    // the count needs one extra bit to represent a full queue.
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_q, halt_d;
    entry_t           mem_q [DEPTH];

    logic             flush;
    logic             pop;
    logic             full;
    logic             enq;
    logic             fetch_adel;
    entry_t           head;
    entry_t           new_entry;

    // Handshake and fetch-enable decode for the current cycle.
    always_comb begin
        flush      = req | eret | redirect;
        deq_valid  = (count_q != '0);
        // A flush kills the pop as well as the enqueue.
        pop        = deq_valid && deq_ready && !flush;
        // A full queue still accepts a fetch when the head leaves this cycle.
        full       = (count_q == CNT_W'(DEPTH)) && !pop;
        enq        = !full && !halt_q && !flush;
        imem_en    = enq;
        imem_addr  = fetch_pc_q;
        fetch_adel = (fetch_pc_q[1:0] != 2'b00)
                  || (fetch_pc_q < ADDR_LO)
                  || (fetch_pc_q > ADDR_HI);
    end

    // Build the entry written on a fetch; a faulting fetch carries no instruction.
    always_comb begin
        new_entry.pc    = fetch_pc_q;
        new_entry.instr = fetch_adel ? 32'h0 : imem_rdata;
        new_entry.adel  = fetch_adel;
    end

    // Present the head entry on the dequeue port.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        deq_pc    = head.pc;
        deq_instr = head.instr;
        deq_adel  = head.adel;
    end

    // Next-state logic for fetch address, pointers, occupancy and halt.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        halt_d     = halt_q;

        if (flush) begin
            // Exception entry outranks exception return, which outranks a branch.
            if (req) begin
                fetch_pc_d = EXC_VECTOR;
            end else if (eret) begin
                fetch_pc_d = epc;
            end else begin
                fetch_pc_d = redirect_pc;
            end
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            halt_d   = 1'b0;
        end else begin
            if (enq) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                if (fetch_adel) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            fetch_pc_q <= PC_START;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
        end
    end

    // Queue storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents are never observed as valid.
        if (!reset && enq) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

`ifdef PREFETCH_IFU_FLUSH_CNT_EN
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating count of flush cycles.
    always_comb begin
        flush_count_d = flush_count_q;
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Flush counter register; reset outranks a same-cycle flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
        end
    end

    assign flush_count = flush_count_q;
`else
    assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_prefetch_ifu.sv
// Testbench for prefetch_ifu: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a queue-based
// behavioural model of the prefetch unit.
module tb_prefetch_ifu;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] PC_START   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] ADDR_LO    = 32'h0000_3000;
    localparam logic [31:0] ADDR_HI    = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_adel;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] flush_count;

    prefetch_ifu #(
        .DEPTH      (DEPTH),
        .PC_START   (PC_START),
        .EXC_VECTOR (EXC_VECTOR),
        .ADDR_LO    (ADDR_LO),
        .ADDR_HI    (ADDR_HI)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .deq_adel    (deq_adel),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .req         (req),
        .eret        (eret),
        .epc         (epc),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_halt;
    logic [31:0] m_fc;
    bit          m_ok = 1'b0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a < ADDR_LO) || (a > ADDR_HI);
    endfunction

    function automatic bit any_flush();
        return req || eret || redirect;
    endfunction

    function automatic bit m_pop();
        return (m_q.size() != 0) && deq_ready && !any_flush();
    endfunction

    // A fetch happens unless flushing, halted, or full without a departure.
    function automatic bit m_fetch();
        if (any_flush() || m_halt) return 1'b0;
        if (m_q.size() == DEPTH && !m_pop()) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_fc();
`ifdef PREFETCH_IFU_FLUSH_CNT_EN
        return m_fc;
`else
        return 32'h0;
`endif
    endfunction

    // Advance the model on each rising edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_pc   = PC_START;
            m_halt = 1'b0;
            m_fc   = 32'h0;
            m_ok   = 1'b1;
        end else if (m_ok) begin
            if (any_flush()) begin
                m_q.delete();
                m_halt = 1'b0;
                m_pc   = req ? EXC_VECTOR : (eret ? epc : redirect_pc);
                if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            end else begin
                bit f;
                bit p;
                f = m_fetch();
                p = m_pop();
                if (p) void'(m_q.pop_front());
                if (f) begin
                    ent_t e;
                    e.pc    = m_pc;
                    e.adel  = bad_addr(m_pc);
                    e.instr = e.adel ? 32'h0 : mem_word(m_pc);
                    m_q.push_back(e);
                    if (e.adel) m_halt = 1'b1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            check("deq_valid", deq_valid, 32'(m_q.size() != 0));
            check("imem_addr", imem_addr, m_pc);
            check("imem_en", imem_en, 32'(m_fetch()));
            check("flush_count", flush_count, exp_fc());
            if (m_q.size() != 0) begin
                check("deq_pc", deq_pc, m_q[0].pc);
                check("deq_instr", deq_instr, m_q[0].instr);
                check("deq_adel", deq_adel, 32'(m_q[0].adel));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 9))
            0:       return 32'h3000 + 32'($urandom_range(0, 32'h3FFF));
            1:       return 32'h6FF0 + 32'($urandom_range(0, 7) * 4);
            2:       return 32'h2FF0 + 32'($urandom_range(0, 7) * 4);
            3:       return $urandom;
            default: return 32'h3000 + 32'($urandom_range(0, 32'hFFF) * 4);
        endcase
    endfunction

    initial begin
        reset       = 1'b1;
        req         = 1'b0;
        eret        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        epc         = 32'h0;
        deq_ready   = 1'b0;
        next_cycle();
        next_cycle();

        // Reset release with the consumer stalled: four fetches, then full.
        reset = 1'b0;
        settle();
        check("rst_deq_valid", deq_valid, 32'h0);
        check("rst_imem_en", imem_en, 32'h1);
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_flush_count", flush_count, 32'h0);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            settle();
            check("fill_addr", imem_addr, 32'h3000 + 32'(4 * i));
            check("fill_en", imem_en, 32'h1);
            check("fill_head", deq_pc, 32'h3000);
        end
        next_cycle();
        settle();
        check("full_en", imem_en, 32'h0);
        check("full_addr", imem_addr, 32'h3010);
        check("full_head", deq_pc, 32'h3000);
        check("full_head_instr", deq_instr, mem_word(32'h3000));
        next_cycle();
        settle();
        check("full_hold_en", imem_en, 32'h0);

        // Full queue streaming: one pop and one fetch every cycle.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            deq_ready = 1'b1;
            settle();
            check("stream_valid", deq_valid, 32'h1);
            check("stream_en", imem_en, 32'h1);
            check("stream_head", deq_pc, 32'h3000 + 32'(4 * i));
            check("stream_addr", imem_addr, 32'h3010 + 32'(4 * i));
        end
        next_cycle();
        deq_ready = 1'b0;
        settle();
        check("stream_end_en", imem_en, 32'h0);
        check("stream_end_head", deq_pc, 32'h3018);

        // Redirect while full.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h3400;
        settle();
        check("redir_en", imem_en, 32'h0);
        next_cycle();
        redirect = 1'b0;
        settle();
        check("redir_valid", deq_valid, 32'h0);
        check("redir_addr", imem_addr, 32'h3400);
        next_cycle();
        settle();
        check("redir_head", deq_pc, 32'h3400);
        check("redir_instr", deq_instr, mem_word(32'h3400));

        // All three flush sources at once: exception entry wins.
        next_cycle();
        req         = 1'b1;
        eret        = 1'b1;
        epc         = 32'h3010;
        redirect    = 1'b1;
        redirect_pc = 32'h3400;
        settle();
        next_cycle();
        req      = 1'b0;
        eret     = 1'b0;
        redirect = 1'b0;
        settle();
        check("prio_addr", imem_addr, 32'h4180);
        check("prio_valid", deq_valid, 32'h0);

        // Misaligned target: faulting entry, then halt until eret.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h3002;
        settle();
        next_cycle();
        redirect = 1'b0;
        settle();
        check("mis_addr", imem_addr, 32'h3002);
        check("mis_en", imem_en, 32'h1);
        next_cycle();
        settle();
        check("mis_adel", deq_adel, 32'h1);
        check("mis_instr", deq_instr, 32'h0);
        check("mis_halt_en", imem_en, 32'h0);
        next_cycle();
        settle();
        check("mis_halt_en2", imem_en, 32'h0);
        next_cycle();
        eret = 1'b1;
        epc  = 32'h3000;
        settle();
        next_cycle();
        eret = 1'b0;
        settle();
        check("eret_addr", imem_addr, 32'h3000);
        check("eret_en", imem_en, 32'h1);

        // Top of the legal range: last good word, then a fault.
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h6FFC;
        settle();
        next_cycle();
        redirect = 1'b0;
        settle();
        check("hi_addr", imem_addr, 32'h6FFC);
        next_cycle();
        settle();
        check("hi_head", deq_pc, 32'h6FFC);
        check("hi_adel", deq_adel, 32'h0);
        check("hi_next_addr", imem_addr, 32'h7000);
        check("hi_next_en", imem_en, 32'h1);
        next_cycle();
        settle();
        check("hi_halt_en", imem_en, 32'h0);
        next_cycle();
        deq_ready = 1'b1;
        settle();
        next_cycle();
        deq_ready = 1'b0;
        settle();
        check("hi_fault_pc", deq_pc, 32'h7000);
        check("hi_fault_adel", deq_adel, 32'h1);
        check("hi_fault_instr", deq_instr, 32'h0);

        // Reset outranks a same-cycle flush and discards queued entries.
        next_cycle();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3400;
        settle();
        next_cycle();
        reset    = 1'b0;
        redirect = 1'b0;
        settle();
        check("rstprio_addr", imem_addr, 32'h3000);
        check("rstprio_valid", deq_valid, 32'h0);
        check("rstprio_en", imem_en, 32'h1);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            reset       = ($urandom_range(0, 199) == 0);
            req         = ($urandom_range(0, 39) == 0);
            eret        = ($urandom_range(0, 29) == 0);
            redirect    = ($urandom_range(0, 14) == 0);
            redirect_pc = pick_target();
            epc         = pick_target();
            deq_ready   = ($urandom_range(0, 2) != 0);
        end
        next_cycle();
        reset    = 1'b0;
        req      = 1'b0;
        eret     = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prefetch_ifu.md
PREFETCH_IFU -- requirements
Module: prefetch_ifu

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PC_START, default 32'h0000_3000, reset fetch address.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, exception handler address.
REQ-004 SHALL have parameters ADDR_LO, default 32'h0000_3000, and ADDR_HI, default 32'h0000_6ffc, legal instruction range (inclusive).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports imem_en  out  1  and imem_addr  out  32: fetch strobe and address.
REQ-008 SHALL have port imem_rdata  in  32  instruction word, combinational, valid in the same cycle as imem_addr.
REQ-009 SHALL have ports deq_valid  out  1, deq_ready  in  1, deq_pc  out  32, deq_instr  out  32, deq_adel  out  1: head-entry handshake.
REQ-010 SHALL have ports redirect  in  1 and redirect_pc  in  32: branch/jump redirect.
REQ-011 SHALL have ports req  in  1, eret  in  1, epc  in  32: exception entry and return.
REQ-012 SHALL have port flush_count  out  32  (see Configuration).

Function
REQ-013 SHALL hold fetch_pc, a FIFO of {pc, instr, adel} entries of DEPTH, and a halt flag.
REQ-014 SHALL drive imem_addr = fetch_pc every cycle; imem_en = !full && !halt && no flush.
REQ-015 SHALL enqueue {fetch_pc, imem_rdata, adel} when imem_en, then fetch_pc <= fetch_pc + 4 (mod 2^32 wrap).
REQ-016 SHALL compute adel = fetch_pc[1:0] != 0 or fetch_pc < ADDR_LO or fetch_pc > ADDR_HI (unsigned).
REQ-017 SHALL store instr = 0 for an adel entry and set halt, stopping fetch until the next flush.
REQ-018 SHALL present the head entry combinationally on deq_*; deq_valid = queue non-empty; enqueue-to-deq_valid latency 1 cycle.
REQ-019 SHALL pop the head when deq_valid && deq_ready.
REQ-020 SHALL, when full, accept an enqueue only if a pop occurs in the same cycle (full = count==DEPTH && !pop).
REQ-021 SHALL treat req, eret, and redirect as flushes: queue emptied, halt cleared, no enqueue and no pop that cycle, imem_en = 0.
REQ-022 SHALL load fetch_pc on a flush with priority req -> EXC_VECTOR, else eret -> epc, else redirect -> redirect_pc.
REQ-023 SHALL fetch from the new target on the cycle after a flush; a flush while empty or halted behaves identically.
REQ-024 SHALL keep count in range 0..DEPTH, with wrap-around read and write pointers.

Reset
REQ-025 SHALL, on reset, set fetch_pc = PC_START, count = 0, pointers = 0, halt = 0, flush_count = 0.
REQ-026 SHALL give reset priority over all inputs, including a flush in the same cycle.
REQ-027 SHALL drive deq_valid = 0 and imem_en = 1 in the first cycle after reset.
REQ-028 SHALL discard all in-flight entries on reset asserted mid-operation.

Configuration
REQ-029 SHALL, with macro PREFETCH_IFU_FLUSH_CNT_EN defined, increment flush_count by 1 on each non-reset flush cycle, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, without PREFETCH_IFU_FLUSH_CNT_EN, tie flush_count to 0 and instantiate no counter logic.

Verification
REQ-031 SHALL test reset release with deq_ready=0: imem_addr 0x3000, 0x3004, 0x3008, 0x300C, then imem_en=0 (full), with head deq_pc=0x3000.
REQ-032 SHALL test full queue with deq_ready=1 on every cycle: one enqueue and one pop per cycle, and count stays at DEPTH.
REQ-033 SHALL test redirect=1 with redirect_pc=0x3400 while full: next cycle deq_valid=0 and imem_addr=0x3400; the following cycle deq_pc=0x3400.
REQ-034 SHALL test req, eret (epc=0x3010) and redirect asserted together: fetch_pc becomes 0x4180.
REQ-035 SHALL test redirect_pc=0x3002: entry has adel=1 and instr=0, imem_en stays 0 afterwards; a subsequent eret (epc=0x3000) resumes fetch.
REQ-036 SHALL test redirect_pc=0x6FFC: entry 0x6FFC has adel=0, the next entry 0x7000 has adel=1, and fetch halts.
